// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter for a single-port pixel RAM.
// Display prefetch reads always win the RAM slot; a one-entry holding
// register feeds writer requests into every slot the display leaves free.
// The pixel stream is delayed by three cycles relative to h_count/v_count,
// so the sync generator must delay h_sync/v_sync by the same amount.
module vga_fb_arbiter #(
    parameter int data_width  = 3,
    parameter int h_width     = 10,
    parameter int v_width     = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = H_ACTIVE >> SCALE_SHIFT,
    parameter int FB_H        = V_ACTIVE >> SCALE_SHIFT,
    parameter int ADDR_W      = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [h_width-1:0]    h_count,
    input  logic [v_width-1:0]    v_count,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [7:0]            wr_x,
    input  logic [6:0]            wr_y,
    input  logic [data_width-1:0] wr_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    output logic [data_width-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  frame_tick,
    output logic [7:0]            wr_drop_cnt
);

    // Cycles from h_count/v_count to the matching pix_data/pix_valid.
    localparam int PIPE_LAT = 3;

    localparam logic [h_width-1:0] H_ACT_L = h_width'(H_ACTIVE);
    localparam logic [v_width-1:0] V_ACT_L = v_width'(V_ACTIVE);
    localparam logic [7:0]         FB_W_L  = 8'(FB_W);
    localparam logic [6:0]         FB_H_L  = 7'(FB_H);
    localparam logic [ADDR_W-1:0]  FB_W_A  = ADDR_W'(FB_W);

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_t;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_DISP,
        SLOT_WR
    } slot_t;

    // Display-side decode
    logic                  video_on;
    logic                  disp_need;
    logic [ADDR_W-1:0]     disp_addr;
    logic                  frame_start;

    // Writer holding register
    hold_state_t           hold_state_reg;
    hold_state_t           hold_state_next;
    logic [ADDR_W-1:0]     hold_addr_reg;
    logic [data_width-1:0] hold_data_reg;
    logic                  wr_ready_reg;
    logic                  wr_ready_next;
    logic                  accept;
    logic                  in_range;
    logic                  capture;
    logic [ADDR_W-1:0]     wr_addr_calc;
    slot_t                 slot;

    // RAM command registers
    logic                  mem_en_reg;
    logic                  mem_we_reg;
    logic [ADDR_W-1:0]     mem_addr_reg;
    logic [data_width-1:0] mem_wdata_reg;

    // Read return and pixel output path
    logic                  rd_return_reg;
    logic [data_width-1:0] pix_latch_reg;
    logic [data_width-1:0] pix_latch_next;
    logic [data_width-1:0] pix_data_reg;
    logic                  pix_valid_reg;
    logic                  vo_last;

    // Status outputs
    logic                  frame_tick_reg;
    logic [7:0]            wr_drop_cnt_reg;

    // Decode the raster position: visibility, fetch slots and fetch address.
    always_comb begin
        video_on    = (h_count < H_ACT_L) && (v_count < V_ACT_L);
        disp_need   = video_on && (h_count[SCALE_SHIFT-1:0] == '0);
        disp_addr   = ADDR_W'(v_count >> SCALE_SHIFT) * FB_W_A
                    + ADDR_W'(h_count >> SCALE_SHIFT);
        frame_start = (h_count == '0) && (v_count == V_ACT_L);
    end

    // Slot arbitration and holding-register next state; display always wins.
    always_comb begin
        hold_state_next = hold_state_reg;
        slot            = SLOT_NONE;
        accept          = wr_valid && wr_ready_reg;
        in_range        = (wr_x < FB_W_L) && (wr_y < FB_H_L);
        capture         = 1'b0;
        wr_addr_calc    = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);

        if (disp_need) begin
            slot = SLOT_DISP;
        end else if (hold_state_reg == HOLD_FULL) begin
            slot = SLOT_WR;
        end

        case (hold_state_reg)
            HOLD_EMPTY: begin
                if (accept && in_range) begin
                    capture         = 1'b1;
                    hold_state_next = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (slot == SLOT_WR) begin
                    hold_state_next = HOLD_EMPTY;
                end
            end
            default: hold_state_next = HOLD_EMPTY;
        endcase

        // Ready stays low through the drain cycle so it re-rises only once
        // the RAM write has actually been presented.
        wr_ready_next = (hold_state_next == HOLD_EMPTY)
                     && (hold_state_reg == HOLD_EMPTY);
    end

    // Holding register state, contents and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_state_reg <= HOLD_EMPTY;
            hold_addr_reg  <= '0;
            hold_data_reg  <= '0;
            wr_ready_reg   <= 1'b0;
        end else begin
            hold_state_reg <= hold_state_next;
            wr_ready_reg   <= wr_ready_next;
            if (capture) begin
                hold_addr_reg <= wr_addr_calc;
                hold_data_reg <= wr_data;
            end
        end
    end

    // Present the slot decision to the RAM one cycle later; idle slots keep
    // address and data steady to avoid needless toggling on the RAM bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (slot)
                SLOT_DISP: begin
                    mem_en_reg   <= 1'b1;
                    mem_we_reg   <= 1'b0;
                    mem_addr_reg <= disp_addr;
                end
                SLOT_WR: begin
                    mem_en_reg    <= 1'b1;
                    mem_we_reg    <= 1'b1;
                    mem_addr_reg  <= hold_addr_reg;
                    mem_wdata_reg <= hold_data_reg;
                end
                default: begin
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    // Mark the cycle in which the RAM returns data for a display read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_return_reg <= 1'b0;
        end else begin
            rd_return_reg <= mem_en_reg && !mem_we_reg;
        end
    end

    // video_on delay line; its last stage lines up with the read return.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT - 1; gi++) begin : g_vo_pipe
            logic stage_in;
            logic stage_reg;
            if (gi == 0) begin : g_first
                assign stage_in = video_on;
            end else begin : g_chain
                assign stage_in = g_vo_pipe[gi-1].stage_reg;
            end
            // One pipeline stage of the visibility flag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign vo_last = g_vo_pipe[PIPE_LAT-2].stage_reg;

    // The latch keeps the last fetched pixel so it repeats across its
    // 2^SCALE_SHIFT screen columns.
    always_comb begin
        pix_latch_next = rd_return_reg ? mem_rdata : pix_latch_reg;
    end

    // Pixel latch and blanked pixel output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_latch_reg <= '0;
            pix_data_reg  <= '0;
            pix_valid_reg <= 1'b0;
        end else begin
            pix_latch_reg <= pix_latch_next;
            pix_valid_reg <= vo_last;
            pix_data_reg  <= vo_last ? pix_latch_next : '0;
        end
    end

    // Single-cycle pulse when the raster enters vertical blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= frame_start;
        end
    end

    // Saturating count of accepted writes that fell outside the framebuffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_cnt_reg <= '0;
        end else if (accept && !in_range && (wr_drop_cnt_reg != 8'hFF)) begin
            wr_drop_cnt_reg <= wr_drop_cnt_reg + 8'd1;
        end
    end

    assign wr_ready    = wr_ready_reg;
    assign mem_en      = mem_en_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign pix_data    = pix_data_reg;
    assign pix_valid   = pix_valid_reg;
    assign frame_tick  = frame_tick_reg;
    assign wr_drop_cnt = wr_drop_cnt_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;

    localparam int DW = 3;
    localparam int HW = 10;
    localparam int VW = 10;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_x;
    logic [6:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          frame_tick;
    logic [7:0]    wr_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int we_cnt   = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .h_count     (h_count),
        .v_count     (v_count),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .frame_tick  (frame_tick),
        .wr_drop_cnt (wr_drop_cnt)
    );

    // Single-port RAM with one-cycle registered read; known contents on reset.
    always @(posedge clk) begin
        if (rst) begin
            ram[0]   <= 3'd5;
            ram[1]   <= 3'd2;
            ram[2]   <= 3'd7;
            ram[161] <= 3'd0;
            ram[325] <= 3'd0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Count RAM reads and writes as the RAM sees them.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) we_cnt <= we_cnt + 1;
            else        rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_pd [15] = '{0, 0, 5, 5, 5, 5, 2, 2, 2, 2, 7, 7, 7, 7, 0};
        int acc;
        int rd0;
        int we0;
        int pat_err;
        int exp_rd;

        rst = 1'b1; h_count = 10'd700; v_count = 10'd0;
        wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 3'd0;

        // Reset: all outputs low
        repeat (5) step();
        check("rst_wr_ready",  32'(wr_ready), 0);
        check("rst_mem_en",    32'(mem_en), 0);
        check("rst_mem_we",    32'(mem_we), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_data",  32'(pix_data), 0);
        check("rst_frame",     32'(frame_tick), 0);
        check("rst_drop",      32'(wr_drop_cnt), 0);

        rst = 1'b0;
        step();
        check("rel_wr_ready", 32'(wr_ready), 1);
        check("rel_mem_en",   32'(mem_en), 0);
        step();
        check("idle_mem_en",  32'(mem_en), 0);

        // Active line h=0..11 then blank: reads at h=0,4,8, pixels 3 cycles late
        for (int i = 0; i < 15; i++) begin
            h_count = (i < 12) ? 10'(i) : 10'd640;
            v_count = 10'd0;
            step();
            check($sformatf("act_en[%0d]", i), 32'(mem_en), (i < 12 && i % 4 == 0) ? 1 : 0);
            check($sformatf("act_we[%0d]", i), 32'(mem_we), 0);
            if (i < 12 && i % 4 == 0)
                check($sformatf("act_addr[%0d]", i), 32'(mem_addr), i / 4);
            check($sformatf("act_pv[%0d]", i), 32'(pix_valid), (i >= 2 && i <= 13) ? 1 : 0);
            check($sformatf("act_pd[%0d]", i), 32'(pix_data), exp_pd[i]);
        end

        // Blanking write x=5 y=2 data=6 -> addr 325
        h_count = 10'd700;
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd2; wr_data = 3'd6;
        check("bw_ready_before", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        check("bw_ready_t1", 32'(wr_ready), 0);
        check("bw_en_t1",    32'(mem_en), 0);
        step();
        check("bw_ready_t2", 32'(wr_ready), 0);
        check("bw_en_t2",    32'(mem_en), 1);
        check("bw_we_t2",    32'(mem_we), 1);
        check("bw_addr_t2",  32'(mem_addr), 325);
        check("bw_wdata_t2", 32'(mem_wdata), 6);
        step();
        check("bw_ready_t3", 32'(wr_ready), 1);
        check("bw_en_t3",    32'(mem_en), 0);
        check("bw_ram325",   32'(ram[325]), 6);

        // Collision: write held while h=8,v=4 needs a read at 162
        h_count = 10'd7; v_count = 10'd4;
        wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd3; wr_data = 3'd1;
        step();
        wr_valid = 1'b0;
        h_count = 10'd8;
        check("col_en_h7", 32'(mem_en), 0);
        step();
        h_count = 10'd9;
        check("col_rd_en",   32'(mem_en), 1);
        check("col_rd_we",   32'(mem_we), 0);
        check("col_rd_addr", 32'(mem_addr), 162);
        step();
        h_count = 10'd10;
        check("col_wr_we",    32'(mem_we), 1);
        check("col_wr_addr",  32'(mem_addr), 490);
        check("col_wr_wdata", 32'(mem_wdata), 1);
        step();
        check("col_en_after", 32'(mem_en), 0);
        check("col_ready",    32'(wr_ready), 1);

        // Full line v=8 with the writer always requesting
        rd0 = rd_cnt; we0 = we_cnt; acc = 0; pat_err = 0;
        v_count = 10'd8;
        for (int h = 0; h < 800; h++) begin
            h_count  = 10'(h);
            wr_valid = 1'b1;
            wr_x     = 8'(acc % 160);
            wr_y     = 7'd100;
            wr_data  = 3'(acc);
            if (wr_ready) acc++;
            step();
            exp_rd = (h < 640 && h % 4 == 0) ? 1 : 0;
            if (32'(mem_en && !mem_we) != exp_rd) pat_err++;
        end
        wr_valid = 1'b0; h_count = 10'd700;
        repeat (4) step();
        check("line_reads",   rd_cnt - rd0, 160);
        check("line_pattern", pat_err, 0);
        check("line_writes",  we_cnt - we0, acc);

        // Out-of-range writes are dropped and counted, saturating at 255
        we0 = we_cnt;
        wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0;
        step();
        check("oor_drop1",  32'(wr_drop_cnt), 1);
        check("oor_ready1", 32'(wr_ready), 1);
        wr_x = 8'd0; wr_y = 7'd120;
        step();
        check("oor_drop2", 32'(wr_drop_cnt), 2);
        wr_x = 8'd255; wr_y = 7'd127;
        repeat (300) step();
        check("oor_sat", 32'(wr_drop_cnt), 255);
        wr_valid = 1'b0;
        step();
        check("oor_no_we", we_cnt - we0, 0);

        // Corner pixel x=159 y=119 is in range -> addr 19199
        wr_valid = 1'b1; wr_x = 8'd159; wr_y = 7'd119; wr_data = 3'd4;
        step();
        wr_valid = 1'b0;
        step();
        check("edge_we",   32'(mem_we), 1);
        check("edge_addr", 32'(mem_addr), 19199);
        check("edge_drop", 32'(wr_drop_cnt), 255);
        step();

        // Frame tick one cycle after h=0,v=480
        h_count = 10'd0; v_count = 10'd480;
        check("ft_before", 32'(frame_tick), 0);
        step();
        h_count = 10'd1;
        check("ft_pulse", 32'(frame_tick), 1);
        step();
        check("ft_after", 32'(frame_tick), 0);

        // Reset while the holding register is full: write is discarded
        h_count = 10'd700; v_count = 10'd0;
        step();
        wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd1; wr_data = 3'd3;
        check("mr_ready_before", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        rst = 1'b1;
        we0 = we_cnt;
        step();
        check("mr_we",    32'(mem_we), 0);
        check("mr_en",    32'(mem_en), 0);
        check("mr_ready", 32'(wr_ready), 0);
        check("mr_drop",  32'(wr_drop_cnt), 0);
        step();
        rst = 1'b0;
        step();
        check("mr_ready_rel", 32'(wr_ready), 1);
        repeat (3) step();
        check("mr_no_write", we_cnt - we0, 0);
        check("mr_ram161",   32'(ram[161]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
